// File: rtl/riscv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package riscv_pkg;

  localparam int MULDIV_ITER = 32;
  localparam int MULDIV_LAT  = 33;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } muldiv_state_t;

  // Magnitude of a value that is signed only when sgn is set.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/riscv_muldiv_unit_sign_fix.sv
// Final conditional negation and result word selection applied in FIX.
module muldiv_sign_fix
  import riscv_pkg::*;
(
  input  logic [63:0] acc_i,
  input  logic        is_div_i,
  input  logic        sel_hi_i,
  input  logic        neg_i,
  output logic [31:0] word_o
);

  logic [63:0] prod_s;
  logic [31:0] div_w_s;

  // Products negate the full 64 bits so the high word carries the borrow.
  always_comb begin
    prod_s  = neg_i ? (~acc_i + 64'd1) : acc_i;
    div_w_s = sel_hi_i ? acc_i[63:32] : acc_i[31:0];
    if (is_div_i) begin
      word_o = neg_i ? (~div_w_s + 32'd1) : div_w_s;
    end else begin
      word_o = sel_hi_i ? prod_s[63:32] : prod_s[31:0];
    end
  end

endmodule

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Divider and special-case handling are built only with RISCV_MULDIV_DIV_EN.
module riscv_muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  muldiv_state_t state_q, state_d;
  logic [63:0]   acc_q, acc_d;
  logic [31:0]   shreg_q, shreg_d;
  logic [31:0]   mcand_q, mcand_d;
  logic [5:0]    cnt_q, cnt_d;
  logic          is_div_q, is_div_d;
  logic          sel_hi_q, sel_hi_d;
  logic          neg_q, neg_d;
  logic          ill_q, ill_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          illegal_q, illegal_d;
  logic [31:0]   res_q, res_d;

  muldiv_op_t    op_s;
  logic          a_sgn_s, b_sgn_s;
  logic [32:0]   sum_s;
  logic [31:0]   fix_word_s;
`ifdef RISCV_MULDIV_DIV_EN
  logic [32:0]   trial_s, diff_s;
`endif

  muldiv_sign_fix u_sign_fix (
    .acc_i    (acc_q),
    .is_div_i (is_div_q),
    .sel_hi_i (sel_hi_q),
    .neg_i    (neg_q),
    .word_o   (fix_word_s)
  );

  // Next-state, datapath step and output decode for the IDLE/CALC/FIX FSM.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    shreg_d   = shreg_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    sel_hi_d  = sel_hi_q;
    neg_d     = neg_q;
    ill_d     = ill_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    res_d     = res_q;

    op_s    = muldiv_op_t'(op);
    a_sgn_s = (op_s == OP_MULH) || (op_s == OP_MULHSU) || (op_s == OP_DIV) || (op_s == OP_REM);
    b_sgn_s = (op_s == OP_MULH) || (op_s == OP_DIV) || (op_s == OP_REM);
    sum_s   = {1'b0, acc_q[63:32]} + {1'b0, (shreg_q[0] ? mcand_q : 32'd0)};
`ifdef RISCV_MULDIV_DIV_EN
    trial_s = {acc_q[63:32], shreg_q[31]};
    diff_s  = trial_s - {1'b0, mcand_q};
`endif

    case (state_q)
      ST_IDLE: begin
        if (start && !kill) begin
          acc_d    = 64'd0;
          cnt_d    = 6'(MULDIV_ITER);
          shreg_d  = mag32(a, a_sgn_s);
          mcand_d  = mag32(b, b_sgn_s);
          is_div_d = op[2];
          sel_hi_d = op[2] ? op[1] : (op[1:0] != 2'b00);
          neg_d    = (op_s == OP_REM) ? a[31] : ((a_sgn_s & a[31]) ^ (b_sgn_s & b[31]));
          ill_d    = 1'b0;
          state_d  = ST_CALC;
`ifdef RISCV_MULDIV_DIV_EN
          // Special cases preload the final word into acc[31:0] and bypass CALC.
          if (op[2] && (b == 32'd0)) begin
            acc_d    = {32'd0, (op[1] ? a : 32'hFFFF_FFFF)};
            sel_hi_d = 1'b0;
            neg_d    = 1'b0;
            state_d  = ST_FIX;
          end else if (((op_s == OP_DIV) || (op_s == OP_REM)) &&
                       (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
            acc_d    = {32'd0, (op[1] ? 32'd0 : 32'h8000_0000)};
            sel_hi_d = 1'b0;
            neg_d    = 1'b0;
            state_d  = ST_FIX;
          end else begin
            state_d  = ST_CALC;
          end
`else
          if (op[2]) begin
            acc_d    = 64'd0;
            sel_hi_d = 1'b0;
            neg_d    = 1'b0;
            ill_d    = 1'b1;
            state_d  = ST_FIX;
          end else begin
            state_d  = ST_CALC;
          end
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        cnt_d   = cnt_q - 6'd1;
        state_d = (cnt_q == 6'd1) ? ST_FIX : ST_CALC;
`ifdef RISCV_MULDIV_DIV_EN
        if (is_div_q) begin
          acc_d   = diff_s[32] ? {trial_s[31:0], acc_q[30:0], 1'b0}
                               : {diff_s[31:0], acc_q[30:0], 1'b1};
          shreg_d = {shreg_q[30:0], 1'b0};
        end else begin
          acc_d   = {sum_s, acc_q[31:1]};
          shreg_d = {1'b0, shreg_q[31:1]};
        end
`else
        acc_d   = {sum_s, acc_q[31:1]};
        shreg_d = {1'b0, shreg_q[31:1]};
`endif
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!kill) begin
          done_d    = 1'b1;
          illegal_d = ill_q;
          res_d     = fix_word_s;
        end else begin
          done_d    = 1'b0;
          illegal_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (kill) begin
      state_d = ST_IDLE;
    end else begin
      state_d = state_d;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= 64'd0;
      shreg_q   <= 32'd0;
      mcand_q   <= 32'd0;
      cnt_q     <= 6'd0;
      is_div_q  <= 1'b0;
      sel_hi_q  <= 1'b0;
      neg_q     <= 1'b0;
      ill_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      res_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      shreg_q   <= shreg_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      sel_hi_q  <= sel_hi_d;
      neg_q     <= neg_d;
      ill_q     <= ill_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      res_q     <= res_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = res_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Randomised self-checking bench for riscv_muldiv_unit with an arithmetic reference model.
module tb_riscv_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        kill = 1'b0;
  logic        busy, done, illegal;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  riscv_muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .kill(kill),
    .busy(busy), .done(done), .result(result), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: result word, illegal flag and edge index of the done pulse.
  function automatic void model_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] r, output logic il, output int lat);
    logic [63:0] p;
    r = 32'd0; il = 1'b0; lat = 33;
    case (o)
      3'd0: begin p = {{32{x[31]}}, x} * {{32{y[31]}}, y}; r = p[31:0];  end
      3'd1: begin p = {{32{x[31]}}, x} * {{32{y[31]}}, y}; r = p[63:32]; end
      3'd2: begin p = {{32{x[31]}}, x} * {32'd0, y};       r = p[63:32]; end
      3'd3: begin p = {32'd0, x} * {32'd0, y};             r = p[63:32]; end
`ifdef RISCV_MULDIV_DIV_EN
      3'd4: begin
        if (y == 32'd0) begin r = 32'hFFFF_FFFF; lat = 1; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin r = 32'h8000_0000; lat = 1; end
        else r = 32'($signed(x) / $signed(y));
      end
      3'd5: begin
        if (y == 32'd0) begin r = 32'hFFFF_FFFF; lat = 1; end
        else r = x / y;
      end
      3'd6: begin
        if (y == 32'd0) begin r = x; lat = 1; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin r = 32'd0; lat = 1; end
        else r = 32'($signed(x) % $signed(y));
      end
      default: begin
        if (y == 32'd0) begin r = x; lat = 1; end
        else r = x % y;
      end
`else
      default: begin r = 32'd0; il = 1'b1; lat = 1; end
`endif
    endcase
  endfunction

  // Transaction-level model of the unit's visible behaviour.
  logic        m_busy = 1'b0, m_done = 1'b0, m_ill = 1'b0, m_exp_ill = 1'b0;
  logic [31:0] m_res = 32'd0, m_exp = 32'd0;
  int          m_age = 0, m_lat = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_ill = 1'b0; m_res = 32'd0;
    end else begin
      m_done = 1'b0; m_ill = 1'b0;
      if (m_busy) begin
        if (kill) m_busy = 1'b0;
        else begin
          m_age++;
          if (m_age == m_lat) begin
            m_busy = 1'b0; m_done = 1'b1; m_res = m_exp; m_ill = m_exp_ill;
          end
        end
      end else if (start && !kill) begin
        m_busy = 1'b1; m_age = 0;
        model_op(op, a, b, m_exp, m_exp_ill, m_lat);
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("busy", {63'd0, busy}, {63'd0, m_busy});
    check("done", {63'd0, done}, {63'd0, m_done});
    check("illegal", {63'd0, illegal}, {63'd0, m_ill});
    check("result", {32'd0, result}, {32'd0, m_res});
  end

  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] er, input logic ei, input int el, input string nm);
    int n;
    bit seen;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (done) seen = 1;
    end
    check({nm, "_lat"}, 64'(n), 64'(el));
    check({nm, "_res"}, {32'd0, result}, {32'd0, er});
    check({nm, "_ill"}, {63'd0, illegal}, {63'd0, ei});
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dones;
    int kc;
    logic [31:0] r;
    logic il;
    int lt;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    model_op(3'd0, 32'd7, 32'hFFFF_FFFD, r, il, lt);
    check("model_mul", {32'd0, r}, {32'd0, 32'hFFFF_FFEB});
    model_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, il, lt);
    check("model_mulhu", {32'd0, r}, {32'd0, 32'hFFFF_FFFE});

    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33, "mul");
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 33, "mulh");
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33, "mulhu");
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33, "mulhsu");
`ifdef RISCV_MULDIV_DIV_EN
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33, "div");
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33, "rem");
    do_op(3'd5, 32'd100, 32'd7, 32'd14, 1'b0, 33, "divu");
    do_op(3'd7, 32'd100, 32'd7, 32'd2, 1'b0, 33, "remu");
    do_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1, "divu_by0");
    do_op(3'd6, 32'd5, 32'd0, 32'd5, 1'b0, 1, "rem_by0");
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1, "div_ovf");
`else
    do_op(3'd4, 32'd6, 32'd3, 32'd0, 1'b1, 1, "div_illegal");
    do_op(3'd7, 32'd100, 32'd7, 32'd0, 1'b1, 1, "remu_illegal");
`endif

    // A start pulse mid-operation must neither restart nor queue.
    op = 3'd0; a = 32'd7; b = 32'hFFFF_FFFD; start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    dones = 0;
    for (int i = 1; i <= 45; i++) begin
      if (i == 10) begin op = 3'd3; a = 32'd1; b = 32'd1; start = 1'b1; end
      else start = 1'b0;
      @(negedge clk);
      if (done) dones++;
    end
    check("ignored_start_dones", 64'(dones), 64'd1);
    check("ignored_start_res", {32'd0, result}, {32'd0, 32'hFFFF_FFEB});

    // Kill mid-operation: no done, previous result retained.
    op = 3'd3; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    repeat (14) @(negedge clk);
    kill = 1'b1;
    @(negedge clk); kill = 1'b0;
    check("kill_busy", {63'd0, busy}, 64'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("kill_dones", 64'(dones), 64'd0);
    check("kill_res", {32'd0, result}, {32'd0, 32'hFFFF_FFEB});

    // Asynchronous reset mid-operation.
    op = 3'd1; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    check("arst_result", {32'd0, result}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Randomised traffic with occasional kills; the compare process checks every cycle.
    for (int t = 0; t < 150; t++) begin
      op = 3'($urandom_range(0, 7)); a = pick(); b = pick();
      kill = ($urandom_range(0, 15) == 0);
      start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0; kill = 1'b0;
      kc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 34)) : 100;
      for (int i = 0; i < 40 && m_busy; i++) begin
        kill = (i == kc);
        @(negedge clk);
      end
      kill = 1'b0;
      check("rand_idle", {63'd0, m_busy}, 64'd0);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
